// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM encoding, tag-width helper and parameter defaults for sdram_host_arb
package sdram_arb_pkg;
    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_HADDR_WIDTH = 24;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_TAG_DEPTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } arb_state_t;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdram_tag_fifo.sv
// sdram_tag_fifo: single-clock tag FIFO; push and pop in one cycle both happen, empty bypasses din to dout
module sdram_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;

    assign full   = r_cnt == (AW+1)'(DEPTH);
    assign empty  = r_cnt == '0;
    assign w_push = push && (!full || pop);
    assign w_pop  = pop && (!empty || push);
    assign dout   = empty ? din : r_mem[r_rp];

    // storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end

    // pointers and occupancy; simultaneous push/pop leaves occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/sdram_host_arb.sv
// sdram_host_arb: multi-channel host arbiter in front of an SDRAM controller; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority
module sdram_host_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TAG_DEPTH   = DEF_TAG_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             ch_wr_enable,
    input  logic [NUM_CH-1:0]             ch_rd_enable,
    input  logic [NUM_CH*HADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_wr_data,
    output logic [NUM_CH-1:0]             ch_ack,
    output logic [DATA_WIDTH-1:0]         ch_rd_data,
    output logic [NUM_CH-1:0]             ch_rd_valid,
    output logic [HADDR_WIDTH-1:0]        wr_addr,
    output logic [HADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_enable,
    output logic                          rd_enable,
    input  logic                          busy,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          rd_ready,
    output logic                          orphan_err
);
    localparam int TW = tag_w(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    arb_state_t             r_state, w_next;
    logic [TW-1:0]          r_win, w_win, w_tag, w_start;
    logic                   r_op_wr, r_wr_en, r_rd_en, r_orphan;
    logic [HADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]  r_data, r_rd_data;
    logic [NUM_CH-1:0]      r_ack, r_rd_valid, w_elig;
    logic                   w_full, w_empty, w_grant, w_accept, w_push;

    // first eligible channel at or after s, wrapping
    function automatic logic [TW-1:0] pick(input logic [NUM_CH-1:0] e, input logic [TW-1:0] s);
        logic [TW-1:0] p;
        p = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (e[(int'(s) + i) % NUM_CH]) p = TW'((int'(s) + i) % NUM_CH);
        return p;
    endfunction

    assign w_elig  = ch_wr_enable | (ch_rd_enable & {NUM_CH{~w_full}});
    assign w_win   = pick(w_elig, w_start);
    assign w_push  = w_accept && !r_op_wr;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [TW-1:0] r_ptr;
    assign w_start = r_ptr;

    // round-robin pointer: next search starts just past the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (w_grant) r_ptr <= (int'(w_win) + 1 == NUM_CH) ? '0 : w_win + TW'(1);
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next state plus grant/accept strobes
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE:  if (!busy && |w_elig) begin w_next = S_ISSUE; w_grant = 1'b1; end
            S_ISSUE: if (busy) begin w_next = S_WAIT; w_accept = 1'b1; end
            S_WAIT:  if (!busy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // latch winner on grant, drop strobe and pulse ack on acceptance; write wins over read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_win   <= w_win;
                r_op_wr <= ch_wr_enable[w_win];
                r_addr  <= ch_addr[int'(w_win)*HADDR_WIDTH +: HADDR_WIDTH];
                r_data  <= ch_wr_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_wr_en <= ch_wr_enable[w_win];
                r_rd_en <= !ch_wr_enable[w_win];
            end
            if (w_accept) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
                r_ack   <= ONE << r_win;
            end
        end
    end

    // read return routing by popped tag; data with no outstanding tag is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_orphan   <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            if (rd_ready) begin
                if (w_empty && !w_push) begin
                    r_orphan <= 1'b1;
                end else begin
                    r_rd_data  <= rd_data;
                    r_rd_valid <= ONE << w_tag;
                end
            end
        end
    end

    sdram_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (rd_ready),
        .din   (r_win),
        .dout  (w_tag),
        .full  (w_full),
        .empty (w_empty)
    );

    assign ch_ack      = r_ack;
    assign ch_rd_data  = r_rd_data;
    assign ch_rd_valid = r_rd_valid;
    assign wr_addr     = r_addr;
    assign rd_addr     = r_addr;
    assign wr_data     = r_data;
    assign wr_enable   = r_wr_en;
    assign rd_enable   = r_rd_en;
    assign orphan_err  = r_orphan;
endmodule

// File: tb/tb_sdram_host_arb.sv
// tb_sdram_host_arb: directed scoreboard bench for sdram_host_arb with a simple controller model
module tb_sdram_host_arb;
    import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  ch_wr_enable, ch_rd_enable;
    logic [47:0] ch_addr;
    logic [31:0] ch_wr_data;
    logic [1:0]  ch_ack, ch_rd_valid;
    logic [15:0] ch_rd_data, wr_data;
    logic [23:0] wr_addr, rd_addr;
    logic        wr_enable, rd_enable, orphan_err;
    logic        busy = 1'b0;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_data = 16'h0;

    always #5 clk = ~clk;

    sdram_host_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_wr_enable (ch_wr_enable),
        .ch_rd_enable (ch_rd_enable),
        .ch_addr      (ch_addr),
        .ch_wr_data   (ch_wr_data),
        .ch_ack       (ch_ack),
        .ch_rd_data   (ch_rd_data),
        .ch_rd_valid  (ch_rd_valid),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .wr_data      (wr_data),
        .wr_enable    (wr_enable),
        .rd_enable    (rd_enable),
        .busy         (busy),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .orphan_err   (orphan_err)
    );

    typedef struct { logic [1:0] ack; bit wr; logic [23:0] addr; logic [15:0] data; } ack_t;
    typedef struct { logic [1:0] v; logic [15:0] d; } rdv_t;

    ack_t        ack_q[$];
    rdv_t        rd_q[$];
    logic [15:0] ret_q[$];
    int errs = 0, checks = 0;
    bit ctl_on = 1'b0, ret_on = 1'b0;
    int orph_req = 0, orph_done = 0, ret_grant = 0, ret_used = 0, bcnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int bound);
        for (int i = 0; i < bound && ack_q.size() > 0; i++) @(negedge clk);
    endtask

    task automatic wait_all(input int bound);
        for (int i = 0; i < bound && (ack_q.size() > 0 || rd_q.size() > 0); i++) @(negedge clk);
    endtask

    task automatic do_reset;
        ctl_on = 1'b0;
        ret_on = 1'b0;
        ch_wr_enable = '0;
        ch_rd_enable = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // controller model: busy for 3 cycles per strobe, reads returned by address low half
    initial forever begin
        @(negedge clk);
        rd_ready = 1'b0;
        if (orph_req != orph_done) begin
            rd_ready = 1'b1;
            rd_data = 16'hDEAD;
            orph_done++;
        end else if (ret_q.size() > 0 && (ret_on || ret_used != ret_grant)) begin
            rd_ready = 1'b1;
            rd_data = ret_q.pop_front();
            if (!ret_on) ret_used++;
        end
        if (!ctl_on) begin
            busy = 1'b0;
            bcnt = 0;
            ret_q.delete();
        end else if (busy) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
        end else if (wr_enable || rd_enable) begin
            busy = 1'b1;
            bcnt = 3;
            if (rd_enable) ret_q.push_back(rd_addr[15:0]);
        end
    end

    // scoreboard: every ack and read-valid pulse must match the head of its queue
    initial begin : mon
        ack_t ea;
        rdv_t er;
        forever begin
            @(negedge clk);
            if (rst_n && |ch_ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 64'(ch_ack), '0);
                else begin
                    ea = ack_q.pop_front();
                    chk("ack_vec", 64'(ch_ack), 64'(ea.ack));
                    if (ea.wr) chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'({ea.addr, ea.data}));
                    else chk("rd_addr", 64'(rd_addr), 64'(ea.addr));
                end
            end
            if (rst_n && |ch_rd_valid) begin
                if (rd_q.size() == 0) chk("rdv_unexpected", 64'(ch_rd_valid), '0);
                else begin
                    er = rd_q.pop_front();
                    chk("rdv_vec", 64'(ch_rd_valid), 64'(er.v));
                    chk("rd_data", 64'(ch_rd_data), 64'(er.d));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_wr_enable = '0;
        ch_rd_enable = '0;
        ch_addr = '0;
        ch_wr_data = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 64'({wr_enable, rd_enable, ch_ack, ch_rd_valid, orphan_err}), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single write on ch0
        ctl_on = 1'b1;
        ch_addr[23:0] = 24'h000010;
        ch_wr_data[15:0] = 16'hBEEF;
        ack_q.push_back('{2'b01, 1'b1, 24'h000010, 16'hBEEF});
        ch_wr_enable = 2'b01;
        @(negedge clk);
        chk("a_issue", 64'({wr_enable, rd_enable, wr_addr, wr_data}), 64'({1'b1, 1'b0, 24'h000010, 16'hBEEF}));
        wait_ack(20);
        ch_wr_enable = '0;
        repeat (5) @(negedge clk);
        chk("a_idle", 64'({dut.r_state, wr_enable}), 64'({S_IDLE, 1'b0}));
        chk("a_q", 64'(ack_q.size()), '0);

        // both channels reading continuously
        do_reset;
        ctl_on = 1'b1;
        ret_on = 1'b1;
        ch_addr = {24'h002222, 24'h001111};
        for (int k = 0; k < 4; k++) begin
            int c;
            c = FIXED ? 0 : k % 2;
            ack_q.push_back('{2'(1 << c), 1'b0, (c == 1) ? 24'h002222 : 24'h001111, 16'h0});
            rd_q.push_back('{2'(1 << c), (c == 1) ? 16'h2222 : 16'h1111});
        end
        ch_rd_enable = 2'b11;
        wait_ack(200);
        ch_rd_enable = '0;
        wait_all(200);
        chk("b_q", 64'(ack_q.size() + rd_q.size()), '0);

        // tag FIFO full: reads stall, writes still served
        do_reset;
        ctl_on = 1'b1;
        ch_addr[23:0] = 24'h001111;
        for (int k = 0; k < 4; k++) ack_q.push_back('{2'b01, 1'b0, 24'h001111, 16'h0});
        ch_rd_enable = 2'b01;
        wait_ack(200);
        chk("c_four_reads", 64'(ack_q.size()), '0);
        ch_addr[47:24] = 24'h000020;
        ch_wr_data[31:16] = 16'h5A5A;
        ack_q.push_back('{2'b10, 1'b1, 24'h000020, 16'h5A5A});
        ch_wr_enable = 2'b10;
        wait_ack(100);
        ch_wr_enable = '0;
        chk("c_write_served", 64'(ack_q.size()), '0);
        repeat (20) @(negedge clk);
        chk("c_stall", 64'({rd_enable, ch_ack}), '0);
        rd_q.push_back('{2'b01, 16'h1111});
        ack_q.push_back('{2'b01, 1'b0, 24'h001111, 16'h0});
        ret_grant++;
        wait_all(200);
        ch_rd_enable = '0;
        chk("c_release", 64'(ack_q.size() + rd_q.size()), '0);

        // orphan read data
        do_reset;
        orph_req++;
        repeat (4) @(negedge clk);
        chk("d_orphan", 64'(orphan_err), 64'(1));
        chk("d_no_valid", 64'(ch_rd_valid), '0);
        repeat (3) @(negedge clk);
        chk("d_sticky", 64'(orphan_err), 64'(1));

        // asynchronous reset while held in ISSUE
        ch_addr[23:0] = 24'h000030;
        ch_wr_data[15:0] = 16'h1234;
        ch_wr_enable = 2'b01;
        repeat (3) @(negedge clk);
        chk("e_in_issue", 64'({dut.r_state, wr_enable}), 64'({S_ISSUE, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("e_async", 64'({wr_enable, rd_enable, orphan_err}), '0);
        ch_wr_enable = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ctl_on = 1'b1;
        repeat (10) @(negedge clk);
        chk("e_idle", 64'({dut.r_state, wr_enable, ch_ack}), 64'({S_IDLE, 1'b0, 2'b00}));

        chk("end_q", 64'(ack_q.size() + rd_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
